// File: rtl/temporal_ngram_fusion_if.sv
// Sample-in / n-gram-out handshake bundle between the spatial encoder,
// the temporal n-gram fusion stage and the associative memory.
interface temporal_ngram_fusion_if #(
   parameter int unsigned HV_DIMENSION = 2000
) ();
   logic                     ValidIn_SI;
   logic                     ReadyOut_SO;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod1_DI;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod2_DI;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod3_DI;
   logic                     Clear_SI;
   logic                     ValidOut_SO;
   logic                     ReadyIn_SI;
   logic [0:HV_DIMENSION-1]  NgramOut_DO;
   logic                     HistoryFull_SO;

   modport slave (
      input  ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
             HypervectorIn_mod3_DI, Clear_SI, ReadyIn_SI,
      output ReadyOut_SO, ValidOut_SO, NgramOut_DO, HistoryFull_SO
   );

   modport master (
      output ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
             HypervectorIn_mod3_DI, Clear_SI, ReadyIn_SI,
      input  ReadyOut_SO, ValidOut_SO, NgramOut_DO, HistoryFull_SO
   );
endinterface

// File: rtl/temporal_ngram_fusion.sv
// Fuses three modality hypervectors by bitwise majority and binds the last
// NGRAM_SIZE fused samples into one temporal n-gram hypervector.
module temporal_ngram_fusion #(
   parameter int unsigned HV_DIMENSION = 2000,
   parameter int unsigned NGRAM_SIZE   = 3
) (
   input  logic                  Clk_CI,
   input  logic                  Reset_RI,
   temporal_ngram_fusion_if.slave bus
);

   localparam int unsigned        CNT_W    = $clog2(NGRAM_SIZE + 1);
   localparam logic [CNT_W-1:0]   FILL_MAX = CNT_W'(NGRAM_SIZE);

   typedef logic [0:HV_DIMENSION-1] hv_t;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPUTE   = 2'd1,
      OUT_VALID = 2'd2
   } state_t;

   function automatic hv_t majority3(input hv_t a, input hv_t b, input hv_t c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // On a [0:N-1] bus a right shift moves index i to i+1, i.e. one step of rho.
   function automatic hv_t rotate_hv(input hv_t x, input int unsigned k);
      int unsigned kk;
      kk = k % HV_DIMENSION;
      return (x >> kk) | (x << (HV_DIMENSION - kk));
   endfunction

   state_t            state_r;
   state_t            state_n_s;
   hv_t               hist_r [NGRAM_SIZE];
   logic [CNT_W-1:0]  fill_r;
   logic [CNT_W-1:0]  fill_n_s;
   logic              full_r;
   hv_t               ngram_r;
   hv_t               fused_s;
   hv_t               ngram_s;
   logic              accept_s;

   assign fused_s  = majority3(bus.HypervectorIn_mod1_DI,
                               bus.HypervectorIn_mod2_DI,
                               bus.HypervectorIn_mod3_DI);
   assign accept_s = (state_r == IDLE) && bus.ValidIn_SI && !bus.Clear_SI;

   // Bind the history: newest sample unrotated, older ones rotated by age.
   always_comb begin
      ngram_s = '0;
      for (int unsigned k = 0; k < NGRAM_SIZE; k++) begin
         ngram_s = ngram_s ^ rotate_hv(hist_r[k], k);
      end
   end

   // Saturating fill count for the next accepted sample.
   always_comb begin
      fill_n_s = fill_r;
      if (fill_r == FILL_MAX) begin
         fill_n_s = fill_r;
      end else begin
         fill_n_s = fill_r + CNT_W'(1);
      end
   end

   // Next-state decode; a flush always returns to IDLE.
   always_comb begin
      state_n_s = state_r;
      if (bus.Clear_SI) begin
         state_n_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.ValidIn_SI) begin
                  state_n_s = COMPUTE;
               end else begin
                  state_n_s = IDLE;
               end
            end
            COMPUTE: begin
               if (fill_r == FILL_MAX) begin
                  state_n_s = OUT_VALID;
               end else begin
                  state_n_s = IDLE;
               end
            end
            OUT_VALID: begin
               if (bus.ReadyIn_SI) begin
                  state_n_s = IDLE;
               end else begin
                  state_n_s = OUT_VALID;
               end
            end
            default: state_n_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge Clk_CI or negedge Reset_RI) begin
      if (!Reset_RI) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Sample history shift register with its fill counter.
   always_ff @(posedge Clk_CI or negedge Reset_RI) begin
      if (!Reset_RI) begin
         for (int unsigned k = 0; k < NGRAM_SIZE; k++) begin
            hist_r[k] <= '0;
         end
         fill_r <= '0;
         full_r <= 1'b0;
      end else if (bus.Clear_SI) begin
         for (int unsigned k = 0; k < NGRAM_SIZE; k++) begin
            hist_r[k] <= '0;
         end
         fill_r <= '0;
         full_r <= 1'b0;
      end else if (accept_s) begin
         hist_r[0] <= fused_s;
         for (int unsigned k = 1; k < NGRAM_SIZE; k++) begin
            hist_r[k] <= hist_r[k-1];
         end
         fill_r <= fill_n_s;
         full_r <= (fill_n_s == FILL_MAX);
      end
   end

   // Output n-gram register; survives a flush so a held result stays intact.
   always_ff @(posedge Clk_CI or negedge Reset_RI) begin
      if (!Reset_RI) begin
         ngram_r <= '0;
      end else if (state_r == COMPUTE) begin
         ngram_r <= ngram_s;
      end
   end

   assign bus.ReadyOut_SO    = (state_r == IDLE);
   assign bus.ValidOut_SO    = (state_r == OUT_VALID);
   assign bus.HistoryFull_SO = full_r;
   assign bus.NgramOut_DO    = ngram_r;

endmodule

// File: tb/tb_temporal_ngram_fusion.sv
// Bench for temporal_ngram_fusion: directed scenarios on three parameter sets
// plus randomized traffic against a cycle-level reference model.
module tb_temporal_ngram_fusion;

   localparam int D = 8;
   typedef logic [0:D-1] hv_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   temporal_ngram_fusion_if #(.HV_DIMENSION(D)) if3 ();
   temporal_ngram_fusion_if #(.HV_DIMENSION(D)) if1 ();
   temporal_ngram_fusion_if #(.HV_DIMENSION(D)) if2 ();

   temporal_ngram_fusion #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) u_n3 (
      .Clk_CI(clk), .Reset_RI(rst_n), .bus(if3));
   temporal_ngram_fusion #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) u_n1 (
      .Clk_CI(clk), .Reset_RI(rst_n), .bus(if1));
   temporal_ngram_fusion #(.HV_DIMENSION(D), .NGRAM_SIZE(2)) u_n2 (
      .Clk_CI(clk), .Reset_RI(rst_n), .bus(if2));

   // reference model state for the NGRAM_SIZE=3 instance
   hv_t m_hist [3];
   int  m_fill;
   int  m_phase;   // 0 waiting for sample, 1 binding, 2 presenting result
   hv_t m_out;

   function automatic hv_t ref_maj(input hv_t a, input hv_t b, input hv_t c);
      hv_t r;
      for (int i = 0; i < D; i++) begin
         r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
      end
      return r;
   endfunction

   function automatic hv_t ref_ngram();
      hv_t r;
      for (int i = 0; i < D; i++) begin
         r[i] = 1'b0;
         for (int k = 0; k < 3; k++) r[i] = r[i] ^ m_hist[k][(i - k + D) % D];
      end
      return r;
   endfunction

   task automatic idle_inputs();
      if3.ValidIn_SI = 1'b0; if3.Clear_SI = 1'b0; if3.ReadyIn_SI = 1'b0;
      if3.HypervectorIn_mod1_DI = '0; if3.HypervectorIn_mod2_DI = '0; if3.HypervectorIn_mod3_DI = '0;
      if1.ValidIn_SI = 1'b0; if1.Clear_SI = 1'b0; if1.ReadyIn_SI = 1'b0;
      if1.HypervectorIn_mod1_DI = '0; if1.HypervectorIn_mod2_DI = '0; if1.HypervectorIn_mod3_DI = '0;
      if2.ValidIn_SI = 1'b0; if2.Clear_SI = 1'b0; if2.ReadyIn_SI = 1'b0;
      if2.HypervectorIn_mod1_DI = '0; if2.HypervectorIn_mod2_DI = '0; if2.HypervectorIn_mod3_DI = '0;
   endtask

   // Offer one sample to the N=3 instance and return two cycles after acceptance.
   task automatic send3(input hv_t a, input hv_t b, input hv_t c);
      int w = 0;
      while (if3.ReadyOut_SO !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (w >= 10) begin
         bad++;
         $display("FAIL send3_ready_timeout: ReadyOut=%b want 1", if3.ReadyOut_SO);
      end
      if3.HypervectorIn_mod1_DI = a; if3.HypervectorIn_mod2_DI = b; if3.HypervectorIn_mod3_DI = c;
      if3.ValidIn_SI = 1'b1;
      @(negedge clk);
      if3.ValidIn_SI = 1'b0;
      @(negedge clk);
   endtask

   task automatic ack3();
      if3.ReadyIn_SI = 1'b1;
      @(negedge clk);
      if3.ReadyIn_SI = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++; if (if3.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", if3.ReadyOut_SO); end
      total++; if (if3.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", if3.ValidOut_SO); end
      total++; if (if3.HistoryFull_SO !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", if3.HistoryFull_SO); end
      total++; if (if3.NgramOut_DO !== 8'b00000000) begin bad++; $display("FAIL rst_ngram: got %b want 00000000", if3.NgramOut_DO); end
      total++; if (if1.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL rst_ready_n1: got %b want 1", if1.ReadyOut_SO); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (if3.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", if3.ReadyOut_SO); end
   endtask

   task automatic test_majority();
      hv_t a [2] = '{8'b11001010, 8'b00001111};
      hv_t b [2] = '{8'b10100110, 8'b00110011};
      hv_t c [2] = '{8'b01101100, 8'b01010101};
      hv_t e [2] = '{8'b11101110, 8'b00010111};
      for (int s = 0; s < 2; s++) begin
         if1.HypervectorIn_mod1_DI = a[s]; if1.HypervectorIn_mod2_DI = b[s]; if1.HypervectorIn_mod3_DI = c[s];
         if1.ValidIn_SI = 1'b1;
         @(negedge clk);
         if1.ValidIn_SI = 1'b0;
         total++; if (if1.ValidOut_SO !== 1'b0 || if1.ReadyOut_SO !== 1'b0) begin
            bad++; $display("FAIL maj_compute_phase: valid=%b ready=%b want 0 0", if1.ValidOut_SO, if1.ReadyOut_SO);
         end
         @(negedge clk);
         total++; if (if1.ValidOut_SO !== 1'b1) begin bad++; $display("FAIL maj_valid: got %b want 1", if1.ValidOut_SO); end
         total++; if (if1.NgramOut_DO !== e[s]) begin bad++; $display("FAIL maj_ngram: got %b want %b", if1.NgramOut_DO, e[s]); end
         if1.ReadyIn_SI = 1'b1;
         @(negedge clk);
         if1.ReadyIn_SI = 1'b0;
         total++; if (if1.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL maj_back_idle: got %b want 1", if1.ReadyOut_SO); end
      end
   endtask

   task automatic test_fill_binding();
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      total++; if (if3.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL fill1_valid: got %b want 0", if3.ValidOut_SO); end
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      total++; if (if3.ValidOut_SO !== 1'b0 || if3.HistoryFull_SO !== 1'b0) begin
         bad++; $display("FAIL fill2: valid=%b full=%b want 0 0", if3.ValidOut_SO, if3.HistoryFull_SO);
      end
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      total++; if (if3.ValidOut_SO !== 1'b1) begin bad++; $display("FAIL fill3_valid: got %b want 1", if3.ValidOut_SO); end
      total++; if (if3.NgramOut_DO !== 8'b11100000) begin bad++; $display("FAIL fill3_ngram: got %b want 11100000", if3.NgramOut_DO); end
      total++; if (if3.HistoryFull_SO !== 1'b1) begin bad++; $display("FAIL fill3_full: got %b want 1", if3.HistoryFull_SO); end
      ack3();
      send3(8'b00000001, 8'b00000001, 8'b00000001);
      total++; if (if3.ValidOut_SO !== 1'b1 || if3.NgramOut_DO !== 8'b01100001) begin
         bad++; $display("FAIL fill4: valid=%b ngram=%b want 1 01100001", if3.ValidOut_SO, if3.NgramOut_DO);
      end
   endtask

   task automatic test_backpressure();
      if3.HypervectorIn_mod1_DI = 8'hFF; if3.HypervectorIn_mod2_DI = 8'hFF; if3.HypervectorIn_mod3_DI = 8'hFF;
      if3.ValidIn_SI = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (if3.ValidOut_SO !== 1'b1 || if3.ReadyOut_SO !== 1'b0 || if3.NgramOut_DO !== 8'b01100001) begin
            bad++; $display("FAIL bp_hold: valid=%b ready=%b ngram=%b want 1 0 01100001",
                            if3.ValidOut_SO, if3.ReadyOut_SO, if3.NgramOut_DO);
         end
      end
      if3.ValidIn_SI = 1'b0;
      ack3();
      total++; if (if3.ReadyOut_SO !== 1'b1 || if3.ValidOut_SO !== 1'b0) begin
         bad++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", if3.ReadyOut_SO, if3.ValidOut_SO);
      end
      send3(8'b00000000, 8'b00000000, 8'b00000000);
      total++; if (if3.NgramOut_DO !== 8'b10100000) begin bad++; $display("FAIL bp_no_capture: got %b want 10100000", if3.NgramOut_DO); end
      ack3();
   endtask

   task automatic test_clear();
      if3.Clear_SI = 1'b1;
      @(negedge clk);
      if3.Clear_SI = 1'b0;
      send3(8'b01000000, 8'b01000000, 8'b01001000);
      send3(8'b00010000, 8'b00010001, 8'b00010000);
      total++; if (if3.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clr_pre_valid: got %b want 0", if3.ValidOut_SO); end
      if3.Clear_SI = 1'b1; if3.ValidIn_SI = 1'b1;
      if3.HypervectorIn_mod1_DI = 8'hFF; if3.HypervectorIn_mod2_DI = 8'hFF; if3.HypervectorIn_mod3_DI = 8'hFF;
      @(negedge clk);
      if3.Clear_SI = 1'b0; if3.ValidIn_SI = 1'b0;
      total++; if (if3.HistoryFull_SO !== 1'b0 || if3.ReadyOut_SO !== 1'b1) begin
         bad++; $display("FAIL clr_state: full=%b ready=%b want 0 1", if3.HistoryFull_SO, if3.ReadyOut_SO);
      end
      @(negedge clk);
      total++; if (if3.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL clr_dropped: ready=%b want 1", if3.ReadyOut_SO); end
      send3(8'b01000000, 8'b01000000, 8'b01000000);
      send3(8'b00010000, 8'b00010000, 8'b00010000);
      total++; if (if3.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clr_second_valid: got %b want 0", if3.ValidOut_SO); end
      send3(8'b00000100, 8'b00000100, 8'b00000100);
      total++; if (if3.ValidOut_SO !== 1'b1 || if3.NgramOut_DO !== 8'b00011100) begin
         bad++; $display("FAIL clr_third: valid=%b ngram=%b want 1 00011100", if3.ValidOut_SO, if3.NgramOut_DO);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (if3.ValidOut_SO !== 1'b0 || if3.NgramOut_DO !== 8'b00000000) begin
         bad++; $display("FAIL arst_immediate: valid=%b ngram=%b want 0 00000000", if3.ValidOut_SO, if3.NgramOut_DO);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (if3.ReadyOut_SO !== 1'b1 || if3.HistoryFull_SO !== 1'b0) begin
         bad++; $display("FAIL arst_release: ready=%b full=%b want 1 0", if3.ReadyOut_SO, if3.HistoryFull_SO);
      end
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      total++; if (if3.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL arst_refill: valid=%b want 0", if3.ValidOut_SO); end
      send3(8'b10000000, 8'b10000000, 8'b10000000);
      total++; if (if3.ValidOut_SO !== 1'b1 || if3.NgramOut_DO !== 8'b11100000) begin
         bad++; $display("FAIL arst_full: valid=%b ngram=%b want 1 11100000", if3.ValidOut_SO, if3.NgramOut_DO);
      end
      ack3();
   endtask

   task automatic test_wrap();
      hv_t s [2] = '{8'b00000001, 8'b10000000};
      for (int i = 0; i < 2; i++) begin
         if2.HypervectorIn_mod1_DI = s[i]; if2.HypervectorIn_mod2_DI = s[i]; if2.HypervectorIn_mod3_DI = s[i];
         if2.ValidIn_SI = 1'b1;
         @(negedge clk);
         if2.ValidIn_SI = 1'b0;
         @(negedge clk);
      end
      total++; if (if2.ValidOut_SO !== 1'b1 || if2.NgramOut_DO !== 8'b00000000) begin
         bad++; $display("FAIL wrap: valid=%b ngram=%b want 1 00000000", if2.ValidOut_SO, if2.NgramOut_DO);
      end
      total++; if (if2.HistoryFull_SO !== 1'b1) begin bad++; $display("FAIL wrap_full: got %b want 1", if2.HistoryFull_SO); end
      if2.ReadyIn_SI = 1'b1;
      @(negedge clk);
      if2.ReadyIn_SI = 1'b0;
   endtask

   task automatic test_random();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) m_hist[k] = '0;
      m_fill = 0; m_phase = 0; m_out = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic vin, rin, clr;
         hv_t a, b, c;
         total++; if (if3.ReadyOut_SO !== (m_phase == 0) || if3.ValidOut_SO !== (m_phase == 2)) begin
            bad++; $display("FAIL rnd_hs cyc %0d: ready=%b valid=%b want %b %b", cyc,
                            if3.ReadyOut_SO, if3.ValidOut_SO, (m_phase == 0), (m_phase == 2));
         end
         total++; if (if3.HistoryFull_SO !== (m_fill == 3)) begin
            bad++; $display("FAIL rnd_full cyc %0d: got %b want %b", cyc, if3.HistoryFull_SO, (m_fill == 3));
         end
         total++; if (if3.NgramOut_DO !== m_out) begin
            bad++; $display("FAIL rnd_ngram cyc %0d: got %b want %b", cyc, if3.NgramOut_DO, m_out);
         end
         vin = ($urandom_range(0, 9) < 7);
         rin = ($urandom_range(0, 9) < 5);
         clr = ($urandom_range(0, 24) == 0);
         a = hv_t'($urandom); b = hv_t'($urandom); c = hv_t'($urandom);
         if3.ValidIn_SI = vin; if3.ReadyIn_SI = rin; if3.Clear_SI = clr;
         if3.HypervectorIn_mod1_DI = a; if3.HypervectorIn_mod2_DI = b; if3.HypervectorIn_mod3_DI = c;
         @(posedge clk);
         if (m_phase == 1) m_out = ref_ngram();
         if (clr) begin
            for (int k = 0; k < 3; k++) m_hist[k] = '0;
            m_fill = 0; m_phase = 0;
         end else begin
            case (m_phase)
               0: if (vin) begin
                     m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = ref_maj(a, b, c);
                     m_fill = (m_fill < 3) ? m_fill + 1 : 3;
                     m_phase = 1;
                  end
               1: m_phase = (m_fill == 3) ? 2 : 0;
               2: if (rin) m_phase = 0;
               default: m_phase = 0;
            endcase
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_majority();
      test_fill_binding();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
